mmu_arbiter: RTL and testbench
==============================

MMU_ARBITER -- requirements
Module: mmu_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, request address width.
REQ-002 Parameter LINE_W, 256, cache-line width.
REQ-003 sys_clk  in  1  single clock, all state on posedge; reset is asynchronous and active-low.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 immu_read  in  1  I-L1 line-fill request, level, held until immu_done.
REQ-006 immu_addr  in  ADDR_W  I-L1 request address.
REQ-007 immu_done  out  1  one-cycle completion pulse to I-L1.
REQ-008 immu_read_data  out  LINE_W  fill line, valid when immu_done=1.
REQ-009 dmmu_read  in  1  D-L1 fill request, level, held until dmmu_done.
REQ-010 dmmu_write  in  1  D-L1 writeback request, level, held until dmmu_done.
REQ-011 dmmu_addr  in  ADDR_W  D-L1 request address.
REQ-012 dmmu_write_data  in  LINE_W  writeback line.
REQ-013 dmmu_done  out  1  one-cycle completion pulse to D-L1.
REQ-014 dmmu_read_data  out  LINE_W  fill line, valid when dmmu_done=1.
REQ-015 mem_req  out  1  backend request, held until mem_ack.
REQ-016 mem_we  out  1  backend write enable.
REQ-017 mem_addr  out  ADDR_W  backend address, line-aligned (low log2(LINE_W/8) bits forced 0).
REQ-018 mem_wdata  out  LINE_W  backend write line.
REQ-019 mem_ack  in  1  backend one-cycle completion.
REQ-020 mem_rdata  in  LINE_W  backend read line, valid with mem_ack.
REQ-021 grant_d  out  1  status: 1 while D-L1 owns backend.

Function
REQ-022 FSM states IDLE, BUSY_I, BUSY_D, RESP; all outputs registered.
REQ-023 IDLE: sample requests; winner latched (addr, we, wdata) -> BUSY_x; mem_req=1 the next cycle (1-cycle grant latency).
REQ-024 dmmu_read and dmmu_write both high: write SHALL be served, read ignored until write done.
REQ-025 BUSY_x: hold mem_req/mem_addr/mem_we/mem_wdata stable; latched values only, requester input changes ignored.
REQ-026 mem_ack in BUSY_x: next cycle mem_req=0, done pulse to owner, read data captured from mem_rdata onto owner's read_data, -> RESP.
REQ-027 RESP: one cycle, no new grant; returns to IDLE; requester drops request during this cycle.
REQ-028 read_data outputs retain last captured line until next completion for that port.
REQ-029 Non-owner done SHALL stay 0; never two done pulses in one cycle.
REQ-030 mem_ack outside BUSY_x SHALL be ignored.
REQ-031 Minimum request-to-done: 3 cycles with mem_ack in first mem_req cycle; back-to-back grants separated by RESP.

Reset
REQ-032 rst_n=0 asynchronously forces IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, immu_done=0, dmmu_done=0, grant_d=0, read_data outputs=0, priority pointer=D.
REQ-033 Reset mid-transaction abandons it; no done pulse follows; first grant after release SHALL be earliest IDLE sample.

Configuration
REQ-034 Macro MMU_ARB_RR_EN defined: round-robin; simultaneous I and D requests in IDLE go to port not served last; pointer updates on every grant.
REQ-035 Macro undefined: fixed priority, D-L1 always wins simultaneous requests; I-L1 served only when D idle.

Verification
REQ-036 Single I read addr 0x0000_1234, mem_ack 2 cycles after mem_req -> mem_addr=0x0000_1220, mem_we=0, immu_done pulse 1 cycle after ack with immu_read_data=mem_rdata.
REQ-037 D write addr 0x40, wdata pattern 0xA5.., held -> mem_we=1, mem_wdata matches, dmmu_done single pulse, immu_done stays 0.
REQ-038 I and D requests same cycle, both held, 3 rounds -> without macro D,D,D served before I; with MMU_ARB_RR_EN order D,I,D.
REQ-039 dmmu_read and dmmu_write both high -> first backend transaction mem_we=1.
REQ-040 rst_n low 1 cycle while BUSY_I, mem_ack arrives after release -> no immu_done, mem_req=0 immediately, ack ignored.
REQ-041 Stray mem_ack in IDLE -> no done pulse, state unchanged.

Source files
------------

// File: rtl/mmu_arbiter_if.sv
// mmu_arbiter_if: bundles the I-L1, D-L1 and backend memory signals of the
// MMU arbiter. The slave modport is the arbiter's view. The master modport is
// the view of the requesters and the memory, as driven by a testbench.
interface mmu_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) ();

  // I-L1 fill port
  logic              immu_read;
  logic [ADDR_W-1:0] immu_addr;
  logic              immu_done;
  logic [LINE_W-1:0] immu_read_data;

  // D-L1 fill / writeback port
  logic              dmmu_read;
  logic              dmmu_write;
  logic [ADDR_W-1:0] dmmu_addr;
  logic [LINE_W-1:0] dmmu_write_data;
  logic              dmmu_done;
  logic [LINE_W-1:0] dmmu_read_data;

  // backend memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;

  // status
  logic              grant_d;

  modport slave (
    input  immu_read, immu_addr,
    output immu_done, immu_read_data,
    input  dmmu_read, dmmu_write, dmmu_addr, dmmu_write_data,
    output dmmu_done, dmmu_read_data,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output grant_d
  );

  modport master (
    output immu_read, immu_addr,
    input  immu_done, immu_read_data,
    output dmmu_read, dmmu_write, dmmu_addr, dmmu_write_data,
    input  dmmu_done, dmmu_read_data,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  grant_d
  );

endinterface

// File: rtl/mmu_arbiter.sv
// mmu_arbiter: shares one line-wide backend port between the I-L1 and D-L1.
// FSM: IDLE -> BUSY_I / BUSY_D -> RESP -> IDLE. All outputs are registered.
// When the D-L1 raises write and read together, the write is served first.
// Optional feature: defining MMU_ARB_RR_EN selects round-robin arbitration.
// Without that macro the arbiter uses fixed priority, and the D-L1 wins ties.
module mmu_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  mmu_arbiter_if.slave   mmu_bus
);

  // byte-offset bits inside one cache line are forced to zero on mem_addr
  localparam int                OFF_W     = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_mem_req,   w_mem_req_nxt;
  logic              r_mem_we,    w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [LINE_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              r_immu_done, w_immu_done_nxt;
  logic              r_dmmu_done, w_dmmu_done_nxt;
  logic [LINE_W-1:0] r_immu_rdata, w_immu_rdata_nxt;
  logic [LINE_W-1:0] r_dmmu_rdata, w_dmmu_rdata_nxt;
  logic              r_grant_d,   w_grant_d_nxt;

  logic              w_d_req;
  logic              w_i_req;
  logic              w_grant_d;
  logic              w_grant_i;

  assign w_d_req = mmu_bus.dmmu_read | mmu_bus.dmmu_write;
  assign w_i_req = mmu_bus.immu_read;

`ifdef MMU_ARB_RR_EN
  // 1: D-L1 wins the next tie; 0: I-L1 wins it
  logic r_prio_d;

  assign w_grant_d = w_d_req & (~w_i_req | r_prio_d);
  assign w_grant_i = w_i_req & (~w_d_req | ~r_prio_d);

  // priority pointer: after every grant, point at the port that did not win
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_d <= 1'b1;
    end else if ((r_state == ST_IDLE) && w_grant_d) begin
      r_prio_d <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_grant_i) begin
      r_prio_d <= 1'b1;
    end else begin
      r_prio_d <= r_prio_d;
    end
  end
`else
  assign w_grant_d = w_d_req;
  assign w_grant_i = w_i_req & ~w_d_req;
`endif

  // state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic; mem_ack only matters while a port owns the backend
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_BUSY_D;
        end else if (w_grant_i) begin
          w_state_nxt = ST_BUSY_I;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mmu_bus.mem_ack) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // output logic: next values of the registered outputs (latched request, done, line)
  always_comb begin
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_grant_d_nxt    = r_grant_d;
    w_immu_rdata_nxt = r_immu_rdata;
    w_dmmu_rdata_nxt = r_dmmu_rdata;
    w_immu_done_nxt  = 1'b0;
    w_dmmu_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = mmu_bus.dmmu_write;
          w_mem_addr_nxt  = mmu_bus.dmmu_addr & ADDR_MASK;
          w_mem_wdata_nxt = mmu_bus.dmmu_write ? mmu_bus.dmmu_write_data : {LINE_W{1'b0}};
          w_grant_d_nxt   = 1'b1;
        end else if (w_grant_i) begin
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = mmu_bus.immu_addr & ADDR_MASK;
          w_mem_wdata_nxt = {LINE_W{1'b0}};
          w_grant_d_nxt   = 1'b0;
        end else begin
          w_mem_req_nxt   = 1'b0;
        end
      end
      ST_BUSY_I: begin
        if (mmu_bus.mem_ack) begin
          w_mem_req_nxt    = 1'b0;
          w_mem_we_nxt     = 1'b0;
          w_immu_done_nxt  = 1'b1;
          w_immu_rdata_nxt = mmu_bus.mem_rdata;
        end else begin
          w_mem_req_nxt    = 1'b1;
        end
      end
      ST_BUSY_D: begin
        if (mmu_bus.mem_ack) begin
          w_mem_req_nxt    = 1'b0;
          w_mem_we_nxt     = 1'b0;
          w_grant_d_nxt    = 1'b0;
          w_dmmu_done_nxt  = 1'b1;
          w_dmmu_rdata_nxt = mmu_bus.mem_rdata;
        end else begin
          w_mem_req_nxt    = 1'b1;
        end
      end
      ST_RESP: begin
        w_mem_req_nxt = 1'b0;
      end
      default: begin
        w_mem_req_nxt = 1'b0;
        w_grant_d_nxt = 1'b0;
      end
    endcase
  end

  // output registers; reset abandons any transaction in flight
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wdata  <= {LINE_W{1'b0}};
      r_grant_d    <= 1'b0;
      r_immu_done  <= 1'b0;
      r_dmmu_done  <= 1'b0;
      r_immu_rdata <= {LINE_W{1'b0}};
      r_dmmu_rdata <= {LINE_W{1'b0}};
    end else begin
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_grant_d    <= w_grant_d_nxt;
      r_immu_done  <= w_immu_done_nxt;
      r_dmmu_done  <= w_dmmu_done_nxt;
      r_immu_rdata <= w_immu_rdata_nxt;
      r_dmmu_rdata <= w_dmmu_rdata_nxt;
    end
  end

  assign mmu_bus.mem_req        = r_mem_req;
  assign mmu_bus.mem_we         = r_mem_we;
  assign mmu_bus.mem_addr       = r_mem_addr;
  assign mmu_bus.mem_wdata      = r_mem_wdata;
  assign mmu_bus.grant_d        = r_grant_d;
  assign mmu_bus.immu_done      = r_immu_done;
  assign mmu_bus.dmmu_done      = r_dmmu_done;
  assign mmu_bus.immu_read_data = r_immu_rdata;
  assign mmu_bus.dmmu_read_data = r_dmmu_rdata;

endmodule

// File: tb/tb_mmu_arbiter.sv
// tb_mmu_arbiter: directed-vector bench for mmu_arbiter. Inputs are driven and
// outputs are sampled on the falling edge, so the DUT registers have settled.
module tb_mmu_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic sys_clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  mmu_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus_if ();

  mmu_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .mmu_bus (bus_if.slave)
  );

  // free-running clock, 10 time-unit period
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // single comparison point: counts every comparison and reports mismatches
  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  // bounded wait for mem_req; an expired budget becomes a failed comparison
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (bus_if.mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, 256'(bus_if.mem_req), 256'd1);
  endtask

  logic [LINE_W-1:0] pat_i;
  logic [LINE_W-1:0] pat_d;
  logic [LINE_W-1:0] pat_w;
  logic              exp_owner_d [4];
  int                d_left;
  int                i_left;
  logic              owner_d;

  // main directed sequence
  initial begin
    n_pass  = 0;
    n_total = 0;
    pat_i   = {8{32'hC0DE_0001}};
    pat_d   = {8{32'h1234_5678}};
    pat_w   = {32{8'hA5}};
`ifdef MMU_ARB_RR_EN
    exp_owner_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_owner_d = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
    rst_n                  = 1'b0;
    bus_if.immu_read       = 1'b0;
    bus_if.immu_addr       = 32'd0;
    bus_if.dmmu_read       = 1'b0;
    bus_if.dmmu_write      = 1'b0;
    bus_if.dmmu_addr       = 32'd0;
    bus_if.dmmu_write_data = 256'd0;
    bus_if.mem_ack         = 1'b0;
    bus_if.mem_rdata       = 256'd0;

    // reset state
    tick();
    tick();
    check_eq("rst_req",   256'(bus_if.mem_req),   256'd0);
    check_eq("rst_we",    256'(bus_if.mem_we),    256'd0);
    check_eq("rst_addr",  256'(bus_if.mem_addr),  256'd0);
    check_eq("rst_wdata", bus_if.mem_wdata,       256'd0);
    check_eq("rst_done",  256'({bus_if.immu_done, bus_if.dmmu_done, bus_if.grant_d}), 256'd0);
    check_eq("rst_rd_i",  bus_if.immu_read_data,  256'd0);
    check_eq("rst_rd_d",  bus_if.dmmu_read_data,  256'd0);
    rst_n = 1'b1;
    tick();

    // single I read; ack two cycles after mem_req rises
    bus_if.immu_read = 1'b1;
    bus_if.immu_addr = 32'h0000_1234;
    tick();
    check_eq("i_req",  256'(bus_if.mem_req),  256'd1);
    check_eq("i_addr", 256'(bus_if.mem_addr), 256'h1220);
    check_eq("i_we",   256'(bus_if.mem_we),   256'd0);
    check_eq("i_gnt",  256'(bus_if.grant_d),  256'd0);
    bus_if.immu_addr = 32'h0000_9999;
    tick();
    check_eq("i_hold_req",  256'(bus_if.mem_req),   256'd1);
    check_eq("i_hold_addr", 256'(bus_if.mem_addr),  256'h1220);
    check_eq("i_early",     256'(bus_if.immu_done), 256'd0);
    bus_if.mem_ack   = 1'b1;
    bus_if.mem_rdata = pat_i;
    tick();
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = 256'd0;
    check_eq("i_done",   256'(bus_if.immu_done), 256'd1);
    check_eq("i_rdata",  bus_if.immu_read_data,  pat_i);
    check_eq("i_dnd",    256'(bus_if.dmmu_done), 256'd0);
    check_eq("i_req_lo", 256'(bus_if.mem_req),   256'd0);
    bus_if.immu_read = 1'b0;
    tick();
    check_eq("i_pulse", 256'(bus_if.immu_done), 256'd0);
    check_eq("i_keep",  bus_if.immu_read_data,  pat_i);

    // D writeback of an 0xA5 pattern to 0x40
    bus_if.dmmu_write      = 1'b1;
    bus_if.dmmu_addr       = 32'h0000_0040;
    bus_if.dmmu_write_data = pat_w;
    tick();
    check_eq("d_req",   256'(bus_if.mem_req),  256'd1);
    check_eq("d_we",    256'(bus_if.mem_we),   256'd1);
    check_eq("d_addr",  256'(bus_if.mem_addr), 256'h40);
    check_eq("d_wdata", bus_if.mem_wdata,      pat_w);
    check_eq("d_gnt",   256'(bus_if.grant_d),  256'd1);
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    check_eq("d_done", 256'(bus_if.dmmu_done), 256'd1);
    check_eq("d_idn",  256'(bus_if.immu_done), 256'd0);
    check_eq("d_gnt0", 256'(bus_if.grant_d),   256'd0);
    bus_if.dmmu_write = 1'b0;
    tick();
    check_eq("d_pulse", 256'(bus_if.dmmu_done), 256'd0);
    check_eq("d_ikeep", bus_if.immu_read_data,  pat_i);

    // D read and write raised together: the write goes to the backend first
    bus_if.dmmu_read  = 1'b1;
    bus_if.dmmu_write = 1'b1;
    bus_if.dmmu_addr  = 32'h0000_0085;
    tick();
    check_eq("rw_we",   256'(bus_if.mem_we),   256'd1);
    check_eq("rw_addr", 256'(bus_if.mem_addr), 256'h80);
    bus_if.mem_ack   = 1'b1;
    bus_if.mem_rdata = pat_d;
    tick();
    bus_if.mem_ack   = 1'b0;
    check_eq("rw_done", 256'(bus_if.dmmu_done), 256'd1);
    bus_if.dmmu_read  = 1'b0;
    bus_if.dmmu_write = 1'b0;
    tick();

    // reset while BUSY_I; the ack after release must be ignored
    bus_if.immu_read = 1'b1;
    bus_if.immu_addr = 32'h0000_2000;
    tick();
    check_eq("rb_req", 256'(bus_if.mem_req), 256'd1);
    rst_n            = 1'b0;
    bus_if.immu_read = 1'b0;
    #1;
    check_eq("rb_async", 256'(bus_if.mem_req), 256'd0);
    tick();
    rst_n          = 1'b1;
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    check_eq("rb_nodone", 256'(bus_if.immu_done), 256'd0);
    check_eq("rb_req0",   256'(bus_if.mem_req),   256'd0);
    check_eq("rb_rd0",    bus_if.immu_read_data,  256'd0);
    tick();
    check_eq("rb_still", 256'({bus_if.immu_done, bus_if.mem_req}), 256'd0);

    // stray ack in IDLE
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    check_eq("st_done", 256'({bus_if.immu_done, bus_if.dmmu_done}), 256'd0);
    check_eq("st_req",  256'(bus_if.mem_req), 256'd0);
    tick();

    // simultaneous I and D requests, re-raised after every completion
    d_left = 3;
    i_left = 3;
    bus_if.immu_read = 1'b1;
    bus_if.immu_addr = 32'h0000_0100;
    bus_if.dmmu_read = 1'b1;
    bus_if.dmmu_addr = 32'h0000_0200;
    for (int g = 0; g < 4; g++) begin
      wait_req($sformatf("arb_req%0d", g));
      owner_d = bus_if.grant_d;
      check_eq($sformatf("arb_own%0d", g), 256'(owner_d), 256'(exp_owner_d[g]));
      check_eq($sformatf("arb_addr%0d", g), 256'(bus_if.mem_addr),
               exp_owner_d[g] ? 256'h200 : 256'h100);
      bus_if.mem_ack = 1'b1;
      tick();
      bus_if.mem_ack = 1'b0;
      check_eq($sformatf("arb_done%0d", g), 256'({bus_if.dmmu_done, bus_if.immu_done}),
               exp_owner_d[g] ? 256'd2 : 256'd1);
      if (owner_d) begin
        bus_if.dmmu_read = 1'b0;
        d_left--;
      end else begin
        bus_if.immu_read = 1'b0;
        i_left--;
      end
      tick();
      if (d_left > 0) begin
        bus_if.dmmu_read = 1'b1;
      end
      if (i_left > 0) begin
        bus_if.immu_read = 1'b1;
      end
    end
    bus_if.immu_read = 1'b0;
    bus_if.dmmu_read = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
